uart_tx_fifo: RTL and testbench

Parametrised next-generation UART transmitter with an integrated transmit FIFO.
Width, baud divider, parity mode, stop-bit count and FIFO depth are configurable.
Accepts words over a valid/ready handshake and serialises them 8N1-style, or per parameters.
Sits behind the Tiny Tapeout top wrapper, replacing the fixed-format transmitter.

---
 rtl/uart_tx_fifo.sv | 145 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated transmit FIFO.
// Frame format (data bits, parity, stop bits) and baud divider are set by parameters.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int CLK_DIV    = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          tx_en,
    input  logic                          tx_valid,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_ready,
    output logic                          uart_txd,
    output logic                          uart_tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    // Parity value 3 is illegal and falls back to no parity.
    localparam bit HAS_PAR = (PARITY == 1) || (PARITY == 2);
    localparam bit ODD_PAR = (PARITY == 2);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wptr, rptr;
    logic [CW-1:0]        count;

    state_e               state;
    logic [BW-1:0]        baud_cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 txd;

    logic                 push, pop, bit_end, frame_done;
    logic [DATA_BITS-1:0] head;

    assign tx_ready     = (count != FULL_CNT);
    assign push         = tx_valid && tx_ready;
    assign head         = mem[rptr];
    assign bit_end      = (baud_cnt == BAUD_LAST);
    assign frame_done   = (state == StStop) && bit_end && (bit_idx == STOP_LAST);
    // A new frame is taken from IDLE or straight off the last stop bit, so frames abut.
    assign pop          = tx_en && (count != '0) && ((state == StIdle) || frame_done);
    assign uart_txd     = txd;
    assign uart_tx_busy = (state != StIdle);
    assign fifo_count   = count;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wptr] <= tx_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= StIdle;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            txd      <= 1'b1;
        end else if (pop) begin
            state    <= StStart;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= head;
            par_bit  <= ODD_PAR ? ~^head : ^head;
            txd      <= 1'b0;
        end else if (state == StIdle) begin
            txd <= 1'b1;
        end else if (!bit_end) begin
            baud_cnt <= baud_cnt + 1'b1;
        end else begin
            baud_cnt <= '0;
            case (state)
                StStart: begin
                    state   <= StData;
                    bit_idx <= '0;
                    txd     <= shreg[0];
                end
                StData: begin
                    if (bit_idx == DATA_LAST) begin
                        bit_idx <= '0;
                        if (HAS_PAR) begin
                            state <= StParity;
                            txd   <= par_bit;
                        end else begin
                            state <= StStop;
                            txd   <= 1'b1;
                        end
                    end else begin
                        bit_idx <= bit_idx + 4'd1;
                        shreg   <= shreg >> 1;
                        txd     <= shreg[1];
                    end
                end
                StParity: begin
                    state   <= StStop;
                    bit_idx <= '0;
                    txd     <= 1'b1;
                end
                StStop: begin
                    if (bit_idx != STOP_LAST) begin
                        bit_idx <= bit_idx + 4'd1;
                    end else begin
                        state <= StIdle;
                        txd   <= 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (no parity / even parity / odd parity with two stop
// bits) share stimulus; a behavioural model feeds per-instance frame scoreboards.
module tb_uart_tx_fifo;

    localparam int CDIV  = 4;
    localparam int DEPTH = 4;
    localparam int NDUT  = 3;

    logic       clock;
    logic       reset;
    logic       tx_en;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic [NDUT-1:0] rdy;
    logic [NDUT-1:0] txd;
    logic [NDUT-1:0] busy;
    logic [2:0] cnt [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        uart_tx_fifo #(
            .DATA_BITS (8),
            .CLK_DIV   (CDIV),
            .PARITY    (g),
            .STOP_BITS (g == 2 ? 2 : 1),
            .FIFO_DEPTH(DEPTH)
        ) dut (
            .clock       (clock),
            .reset       (reset),
            .tx_en       (tx_en),
            .tx_valid    (tx_valid),
            .tx_data     (tx_data),
            .tx_ready    (rdy[g]),
            .uart_txd    (txd[g]),
            .uart_tx_busy(busy[g]),
            .fifo_count  (cnt[g])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic end_req = 1'b0;
    logic end_done = 1'b0;

    // Reference model state: queued words, cycles left in the current frame.
    logic [7:0]  mq  [NDUT][$];
    logic [15:0] sbq [NDUT][$];
    int          rem [NDUT];
    logic        infr [NDUT];
    int          pos [NDUT];
    logic [15:0] cur [NDUT];

    function automatic int flen(input int d);
        return (1 + 8 + (d != 0 ? 1 : 0) + (d == 2 ? 2 : 1)) * CDIV;
    endfunction

    // Line level for each bit slot of a frame: start, data LSB first, parity, then stop ones.
    function automatic logic [15:0] frame_bits(input logic [7:0] w, input int d);
        logic [15:0] v;
        v      = '1;
        v[0]   = 1'b0;
        v[8:1] = w;
        if (d == 1) v[9] = ^w;
        if (d == 2) v[9] = ~(^w);
        return v;
    endfunction

    task automatic check(input string nm, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, d, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        for (int d = 0; d < NDUT; d++) begin
            if (reset) begin
                mq[d].delete();
                sbq[d].delete();
                rem[d]  = 0;
                infr[d] = 1'b0;
                pos[d]  = 0;
                check("reset_txd", d, int'(txd[d]), 1);
                check("reset_busy", d, int'(busy[d]), 0);
                check("reset_ready", d, int'(rdy[d]), 1);
                check("reset_count", d, int'(cnt[d]), 0);
            end else begin
                check("busy", d, int'(busy[d]), (rem[d] > 0) ? 1 : 0);
                check("count", d, int'(cnt[d]), mq[d].size());
                check("ready", d, int'(rdy[d]), (mq[d].size() < DEPTH) ? 1 : 0);
                if (!infr[d] && txd[d] == 1'b0) begin
                    check("start_expected", d, (sbq[d].size() > 0) ? 1 : 0, 1);
                    if (sbq[d].size() > 0) begin
                        cur[d]  = sbq[d].pop_front();
                        infr[d] = 1'b1;
                        pos[d]  = 0;
                    end
                end
                if (infr[d]) begin
                    check("frame_bit", d, int'(txd[d]), int'(cur[d][pos[d] / CDIV]));
                    pos[d]++;
                    if (pos[d] == flen(d)) infr[d] = 1'b0;
                end

                // Predict the coming clock edge from the inputs now on the pins.
                begin
                    logic push_m;
                    push_m = tx_valid && (mq[d].size() < DEPTH);
                    if (rem[d] > 1) begin
                        rem[d]--;
                    end else if (tx_en && mq[d].size() > 0) begin
                        sbq[d].push_back(frame_bits(mq[d].pop_front(), d));
                        rem[d] = flen(d);
                    end else begin
                        rem[d] = 0;
                    end
                    if (push_m) mq[d].push_back(tx_data);
                end
            end
        end
        if (end_req && !end_done) begin
            end_done = 1'b1;
            for (int d = 0; d < NDUT; d++) begin
                check("frames_left", d, sbq[d].size(), 0);
                check("frame_open", d, int'(infr[d]), 0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic put(input logic [7:0] w);
        tx_valid = 1'b1;
        tx_data  = w;
        @(posedge clock);
        #1;
        tx_valid = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        tx_en    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        idle(3);
        reset = 1'b0;
        idle(2);

        // Single frames, including the parity case.
        tx_en = 1'b1;
        put(8'hA5);
        idle(60);
        put(8'h07);
        idle(60);

        // Fill past full with transmission held off, then release.
        tx_en = 1'b0;
        for (int i = 1; i <= 5; i++) put(8'(i * 8'h13));
        idle(3);
        tx_en = 1'b1;
        idle(260);

        // All-ones words back to back expose the stop-bit period.
        put(8'hFF);
        put(8'hFF);
        idle(120);

        // Reset during the third data bit with two more words queued.
        tx_en = 1'b0;
        put(8'h3C);
        put(8'h81);
        put(8'h42);
        tx_en = 1'b1;
        idle(13);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(60);

        // Drop tx_en mid-frame with one word still queued.
        put(8'h5A);
        put(8'hC3);
        idle(10);
        tx_en = 1'b0;
        idle(80);
        tx_en = 1'b1;
        idle(80);

        for (int i = 0; i < 1500; i++) begin
            if (i % 25 == 0) tx_en = ($urandom_range(0, 4) != 0);
            tx_valid = ($urandom_range(0, 9) < 3);
            tx_data  = 8'($urandom);
            @(posedge clock);
            #1;
        end
        tx_valid = 1'b0;
        tx_en    = 1'b1;
        idle(300);

        end_req = 1'b1;
        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
